// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter: lets two AXI-Lite masters (s0 = imem, s1 = dmem) share one AXI-Lite RAM.
// One read or write is in flight at a time; responses pass through unchanged.
// Build option: define AXIL_ARB_FIXED_PRIO_EN to make port 1 win every conflict (port 0 may
// starve). Without it, conflicts are resolved round-robin.
module axil_mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    // port 0 (instruction)
    input  logic [ADDR_W-1:0] s0_awaddr,
    input  logic              s0_awvalid,
    output logic              s0_awready,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic [STRB_W-1:0] s0_wstrb,
    input  logic              s0_wvalid,
    output logic              s0_wready,
    output logic [1:0]        s0_bresp,
    output logic              s0_bvalid,
    input  logic              s0_bready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    // port 1 (data)
    input  logic [ADDR_W-1:0] s1_awaddr,
    input  logic              s1_awvalid,
    output logic              s1_awready,
    input  logic [DATA_W-1:0] s1_wdata,
    input  logic [STRB_W-1:0] s1_wstrb,
    input  logic              s1_wvalid,
    output logic              s1_wready,
    output logic [1:0]        s1_bresp,
    output logic              s1_bvalid,
    input  logic              s1_bready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    // shared RAM
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StRdAddr = 3'd1;
    localparam logic [2:0] StRdData = 3'd2;
    localparam logic [2:0] StWrAddr = 3'd3;
    localparam logic [2:0] StWrResp = 3'd4;

    logic [2:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic rdreq0, rdreq1, req0, req1, pick, pick_rd;

    // A write only counts as a request once both AW and W are pending.
    assign rdreq0  = s0_arvalid;
    assign rdreq1  = s1_arvalid;
    assign req0    = rdreq0 | (s0_awvalid & s0_wvalid);
    assign req1    = rdreq1 | (s1_awvalid & s1_wvalid);
`ifdef AXIL_ARB_FIXED_PRIO_EN
    assign pick    = req1;
`else
    assign pick    = (req0 & req1) ? rr_ptr_q : req1;
`endif
    assign pick_rd = pick ? rdreq1 : rdreq0;

    // Next-state logic: arbitration in idle, handshake tracking while a transaction is open.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            StIdle: begin
                if (req0 | req1) begin
                    grant_d = pick;
                    state_d = pick_rd ? StRdAddr : StWrAddr;
                end
            end
            StRdAddr: begin
                if (m_arready) state_d = StRdData;
            end
            StRdData: begin
                if (m_rvalid && m_rready) begin
                    state_d  = StIdle;
                    rr_ptr_d = ~grant_q;
                end
            end
            StWrAddr: begin
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d   = StWrResp;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            StWrResp: begin
                if (m_bvalid && m_bready) begin
                    state_d  = StIdle;
                    rr_ptr_d = ~grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Channel steering: only the granted port sees readies and responses; all quiet in reset.
    always_comb begin
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0;
        m_bready = 1'b0; m_araddr = '0; m_arvalid = 1'b0; m_rready = 1'b0;
        s0_awready = 1'b0; s0_wready = 1'b0; s0_bresp = '0; s0_bvalid = 1'b0;
        s0_arready = 1'b0; s0_rdata = '0; s0_rresp = '0; s0_rvalid = 1'b0;
        s1_awready = 1'b0; s1_wready = 1'b0; s1_bresp = '0; s1_bvalid = 1'b0;
        s1_arready = 1'b0; s1_rdata = '0; s1_rresp = '0; s1_rvalid = 1'b0;
        if (rst) begin
            case (state_q)
                StRdAddr: begin
                    m_araddr  = grant_q ? s1_araddr : s0_araddr;
                    m_arvalid = 1'b1;
                    if (grant_q) s1_arready = m_arready;
                    else         s0_arready = m_arready;
                end
                StRdData: begin
                    if (grant_q) begin
                        s1_rdata = m_rdata; s1_rresp = m_rresp; s1_rvalid = m_rvalid;
                        m_rready = s1_rready;
                    end else begin
                        s0_rdata = m_rdata; s0_rresp = m_rresp; s0_rvalid = m_rvalid;
                        m_rready = s0_rready;
                    end
                end
                StWrAddr: begin
                    m_awaddr  = grant_q ? s1_awaddr : s0_awaddr;
                    m_wdata   = grant_q ? s1_wdata : s0_wdata;
                    m_wstrb   = grant_q ? s1_wstrb : s0_wstrb;
                    m_awvalid = ~aw_done_q;
                    m_wvalid  = ~w_done_q;
                    if (grant_q) begin
                        s1_awready = m_awready & ~aw_done_q;
                        s1_wready  = m_wready & ~w_done_q;
                    end else begin
                        s0_awready = m_awready & ~aw_done_q;
                        s0_wready  = m_wready & ~w_done_q;
                    end
                end
                StWrResp: begin
                    if (grant_q) begin
                        s1_bresp = m_bresp; s1_bvalid = m_bvalid; m_bready = s1_bready;
                    end else begin
                        s0_bresp = m_bresp; s0_bvalid = m_bvalid; m_bready = s0_bready;
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            grant_q   <= 1'b0;
            rr_ptr_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Bench for axil_mem_arbiter: behavioural AXI-Lite RAM on the master side, two port drivers,
// per-port response scoreboards filled at issue time and drained on each response.
module tb_axil_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] s_awaddr [2];
    logic        s_awvalid[2];
    logic        s_awready[2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic        s_wvalid [2];
    logic        s_wready [2];
    logic [1:0]  s_bresp  [2];
    logic        s_bvalid [2];
    logic        s_bready [2];
    logic [31:0] s_araddr [2];
    logic        s_arvalid[2];
    logic        s_arready[2];
    logic [31:0] s_rdata  [2];
    logic [1:0]  s_rresp  [2];
    logic        s_rvalid [2];
    logic        s_rready [2];

    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;

    axil_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]),
        .s0_wready(s_wready[0]), .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]),
        .s0_bready(s_bready[0]), .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]),
        .s0_arready(s_arready[0]), .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]),
        .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]),
        .s1_wready(s_wready[1]), .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]),
        .s1_bready(s_bready[1]), .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]),
        .s1_arready(s_arready[1]), .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]),
        .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int errors = 0;
    int checks = 0;

    // RAM model: addresses with nonzero upper half answer SLVERR with zero data.
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        m_wready_en = 1'b1;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_l, w_data_l;
    logic [3:0]  w_strb_l;

    assign m_arready = 1'b1;
    assign m_awready = 1'b1;
    assign m_wready  = m_wready_en;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
            m_bvalid <= 1'b0; m_bresp <= '0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
        end else begin
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                if (m_araddr[31:16] != 16'h0) begin
                    m_rresp <= 2'b10; m_rdata <= '0;
                end else begin
                    m_rresp <= 2'b00; m_rdata <= mem[m_araddr[9:2]];
                end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_addr_l <= m_awaddr; end
            if (m_wvalid && m_wready) begin
                w_got <= 1'b1; w_data_l <= m_wdata; w_strb_l <= m_wstrb;
            end
            if (aw_got && w_got && !m_bvalid) begin
                mem[aw_addr_l[9:2]] <= merge(mem[aw_addr_l[9:2]], w_data_l, w_strb_l);
                m_bvalid <= 1'b1; m_bresp <= 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
        end
    end

    logic [33:0] exp_r0[$], exp_r1[$];
    logic [1:0]  exp_b0[$], exp_b1[$];
    int          gnt_order[$];
    int          rsp_cnt[2];
    int          exp_rr = 0;

    // Read on port p; caller is at a negedge. stall = cycles rready held low after rvalid.
    task automatic do_read(input int p, input logic [31:0] addr, input int stall, input bit chk);
        int n;
        logic [33:0] e, got;
        e = (addr[31:16] != 16'h0) ? {2'b10, 32'h0} : {2'b00, ref_mem[addr[9:2]]};
        if (p == 0) exp_r0.push_back(e); else exp_r1.push_back(e);
        s_araddr[p] = addr; s_arvalid[p] = 1'b1;
        if (chk) begin
            checks++;
            if (m_arvalid !== 1'b0) begin
                errors++; $display("FAIL ar_early p%0d: m_arvalid=%b want 0", p, m_arvalid);
            end
        end
        n = 0;
        while (s_arready[p] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL ar_timeout p%0d: no arready in %0d cycles", p, n);
            s_arvalid[p] = 1'b0; return;
        end
        if (chk) begin
            checks++;
            if (n != 1 || m_arvalid !== 1'b1) begin
                errors++;
                $display("FAIL ar_latency p%0d: cycles=%0d m_arvalid=%b want 1/1", p, n, m_arvalid);
            end
            checks++;
            if ({s_arready[1-p], s_awready[1-p], s_wready[1-p]} !== 3'b000) begin
                errors++;
                $display("FAIL other_ready p%0d: got %b%b%b want 000", 1-p, s_arready[1-p],
                         s_awready[1-p], s_wready[1-p]);
            end
        end
        gnt_order.push_back(p);
        @(negedge clk);
        s_arvalid[p] = 1'b0; s_araddr[p] = '0;
        n = 0;
        while (s_rvalid[p] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL r_timeout p%0d: no rvalid in %0d cycles", p, n); return;
        end
        repeat (stall) begin
            checks++;
            if (m_rready !== 1'b0 || s_arready[1-p] !== 1'b0) begin
                errors++;
                $display("FAIL r_stall p%0d: m_rready=%b other_arready=%b want 0/0", p, m_rready,
                         s_arready[1-p]);
            end
            @(negedge clk);
        end
        s_rready[p] = 1'b1;
        got = {s_rresp[p], s_rdata[p]};
        if (p == 0) e = (exp_r0.size() > 0) ? exp_r0.pop_front() : 34'h3_FFFF_FFFF;
        else        e = (exp_r1.size() > 0) ? exp_r1.pop_front() : 34'h3_FFFF_FFFF;
        checks++;
        if (got !== e) begin
            errors++; $display("FAIL rdata p%0d addr %h: got %h want %h", p, addr, got, e);
        end
        rsp_cnt[p]++;
        @(negedge clk);
        s_rready[p] = 1'b0;
        exp_rr = 1 - p;
    endtask

    // Write on port p; AW is presented `lead` cycles before W.
    task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead);
        int n;
        bit a, w, aw_ok, w_ok;
        logic [1:0] e;
        ref_mem[addr[9:2]] = merge(ref_mem[addr[9:2]], data, strb);
        if (p == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
        s_awaddr[p] = addr; s_awvalid[p] = 1'b1;
        repeat (lead) begin
            @(negedge clk);
            checks++;
            if (m_awvalid !== 1'b0) begin
                errors++; $display("FAIL aw_without_w p%0d: m_awvalid=%b want 0", p, m_awvalid);
            end
        end
        s_wdata[p] = data; s_wstrb[p] = strb; s_wvalid[p] = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 100) begin
            a = (s_awready[p] === 1'b1) && s_awvalid[p];
            w = (s_wready[p] === 1'b1) && s_wvalid[p];
            @(negedge clk);
            if (a) begin s_awvalid[p] = 1'b0; aw_ok = 1; end
            if (w) begin s_wvalid[p] = 1'b0; w_ok = 1; end
            n++;
        end
        checks++;
        if (!(aw_ok && w_ok)) begin
            errors++; $display("FAIL w_timeout p%0d: aw=%0d w=%0d want 1/1", p, aw_ok, w_ok);
            s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; return;
        end
        gnt_order.push_back(p);
        n = 0;
        while (s_bvalid[p] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL b_timeout p%0d: no bvalid in %0d cycles", p, n); return;
        end
        s_bready[p] = 1'b1;
        if (p == 0) e = (exp_b0.size() > 0) ? exp_b0.pop_front() : 2'b11;
        else        e = (exp_b1.size() > 0) ? exp_b1.pop_front() : 2'b11;
        checks++;
        if (s_bresp[p] !== e) begin
            errors++; $display("FAIL bresp p%0d: got %b want %b", p, s_bresp[p], e);
        end
        @(negedge clk);
        s_bready[p] = 1'b0;
        exp_rr = 1 - p;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        s_arvalid[0] = 1'b1; s_araddr[0] = 32'h100;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid[0], s_bvalid[1], s_rvalid[0],
             s_rvalid[1]} !== 7'b0) begin
            errors++; $display("FAIL reset_valids: got %b%b%b want 000", m_awvalid, m_wvalid,
                                m_arvalid);
        end
        checks++;
        if ({s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_arready[0], s_arready[1],
             m_bready, m_rready} !== 8'b0) begin
            errors++; $display("FAIL reset_readies: arready=%b%b want 00", s_arready[0],
                                s_arready[1]);
        end
        checks++;
        if ((m_araddr | m_awaddr | m_wdata | s_rdata[0] | s_rdata[1]) !== 32'h0) begin
            errors++; $display("FAIL reset_data: m_araddr=%h s0_rdata=%h want 0", m_araddr,
                                s_rdata[0]);
        end
        s_arvalid[0] = 1'b0; s_araddr[0] = '0;
        rst = 1'b1; exp_rr = 0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        do_read(0, 32'h0000_0100, 0, 1);
        checks++;
        if (mem[64] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ram_preload: got %h want deadbeef", mem[64]);
        end
        do_read(0, 32'h0001_0000, 0, 1);   // SLVERR passthrough
    endtask

    task automatic test_write_then_read();
        do_write(1, 32'h200, 32'h1234_5678, 4'hF, 2);
        do_read(1, 32'h200, 0, 1);
        do_write(0, 32'h204, 32'hAABB_CCDD, 4'b0101, 0);
        do_read(0, 32'h204, 0, 1);
    endtask

    task automatic test_round_robin();
        int first;
        bit alt;
        gnt_order.delete(); rsp_cnt[0] = 0; rsp_cnt[1] = 0; first = exp_rr;
        fork
            begin for (int i = 0; i < 4; i++) do_read(0, 32'(32'h40 + 4*i), 0, 0); end
            begin for (int i = 0; i < 4; i++) do_read(1, 32'(32'h80 + 4*i), 0, 0); end
        join
        checks++;
        if (gnt_order.size() != 8) begin
            errors++; $display("FAIL rr_count: got %0d grants want 8", gnt_order.size());
        end else begin
            checks++;
            if (gnt_order[0] != first) begin
                errors++; $display("FAIL rr_first: got %0d want %0d", gnt_order[0], first);
            end
            alt = 1;
            for (int i = 1; i < 8; i++) if (gnt_order[i] == gnt_order[i-1]) alt = 0;
            checks++;
            if (!alt) begin
                errors++; $display("FAIL rr_alternate: got %p want alternating", gnt_order);
            end
        end
        checks++;
        if (rsp_cnt[0] != 4 || rsp_cnt[1] != 4) begin
            errors++; $display("FAIL rr_responses: got %0d/%0d want 4/4", rsp_cnt[0], rsp_cnt[1]);
        end
    endtask

    task automatic test_fixed_prio();
        gnt_order.delete();
        fork
            do_read(0, 32'h40, 0, 0);
            begin for (int i = 0; i < 4; i++) do_read(1, 32'(32'h80 + 4*i), 0, 0); end
        join
        checks++;
        if (gnt_order.size() != 5) begin
            errors++; $display("FAIL fp_count: got %0d grants want 5", gnt_order.size());
        end else begin
            checks++;
            if (gnt_order[0] != 1 || gnt_order[1] != 1 || gnt_order[2] != 1 ||
                gnt_order[3] != 1 || gnt_order[4] != 0) begin
                errors++; $display("FAIL fp_order: got %p want 1,1,1,1,0", gnt_order);
            end
        end
    endtask

    task automatic test_rready_stall();
        gnt_order.delete();
        fork
            do_read(0, 32'h0000_0100, 5, 0);
            begin @(negedge clk); do_read(1, 32'h200, 0, 0); end
        join
        checks++;
        if (gnt_order.size() != 2 || gnt_order[0] != 0 || gnt_order[1] != 1) begin
            errors++; $display("FAIL stall_order: got %p want 0,1", gnt_order);
        end
    endtask

    task automatic test_reset_mid_write();
        int n;
        m_wready_en = 1'b0;
        s_awaddr[0] = 32'h300; s_awvalid[0] = 1'b1;
        s_wdata[0] = 32'hCAFE_F00D; s_wstrb[0] = 4'hF; s_wvalid[0] = 1'b1;
        n = 0;
        while (s_awready[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin errors++; $display("FAIL mid_aw_timeout: no awready"); end
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        checks++;
        if ({m_awvalid, m_wvalid, s_awready[0]} !== 3'b010) begin
            errors++; $display("FAIL aw_done_hold: got %b%b%b want 010", m_awvalid, m_wvalid,
                                s_awready[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, s_bvalid[0], s_rvalid[0]} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_valids: got %b%b%b want 000", m_awvalid,
                                m_wvalid, m_arvalid);
        end
        checks++;
        if ({s_awready[0], s_wready[0], s_arready[0], m_bready, m_rready} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_readies: wready=%b want 0", s_wready[0]);
        end
        s_wvalid[0] = 1'b0; rst = 1'b1; m_wready_en = 1'b1; exp_rr = 0;
        @(negedge clk);
        checks++;
        if ({m_awvalid, m_wvalid} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got %b%b want 00", m_awvalid, m_wvalid);
        end
        do_read(0, 32'h300, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        mem[64] = 32'hDEAD_BEEF; ref_mem[64] = 32'hDEAD_BEEF;
        for (int p = 0; p < 2; p++) begin
            s_awaddr[p] = '0; s_awvalid[p] = 1'b0; s_wdata[p] = '0; s_wstrb[p] = '0;
            s_wvalid[p] = 1'b0; s_bready[p] = 1'b0; s_araddr[p] = '0; s_arvalid[p] = 1'b0;
            s_rready[p] = 1'b0; rsp_cnt[p] = 0;
        end
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_read();
        test_write_then_read();
`ifdef AXIL_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_rready_stall();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axil_mem_arbiter.md
Name: axil_mem_arbiter

Overview:
- Two-master to one-slave AXI-Lite arbiter. Lets the SCR1 instruction port (s0) and data port (s1) share a single axil_ram_wrap instance, which holds unified code and data memory.
- Sits between scr1_top_axi_wrap's imem/dmem AXI-Lite buses and the RAM wrapper.
- Runs one transaction at a time, read or write, with fair round-robin between masters.
- Response data and status pass through unchanged.

Parameters:
ADDR_W, 32, address width of all AW/AR channels
DATA_W, 32, data width of W/R channels; STRB_W = DATA_W/8

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-low reset
sN_awaddr/sN_awvalid/sN_awready (N=0,1)  in/in/out  ADDR_W/1/1  slave write-address channel
sN_wdata/sN_wstrb/sN_wvalid/sN_wready  in/in/in/out  DATA_W/STRB_W/1/1  slave write-data channel
sN_bresp/sN_bvalid/sN_bready  out/out/in  2/1/1  slave write-response channel
sN_araddr/sN_arvalid/sN_arready  in/in/out  ADDR_W/1/1  slave read-address channel
sN_rdata/sN_rresp/sN_rvalid/sN_rready  out/out/out/in  DATA_W/2/1/1  slave read-data channel
m_awaddr/m_awvalid/m_awready  out/out/in  ADDR_W/1/1  master write-address channel to RAM
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/STRB_W/1/1  master write-data channel
m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  master write-response channel
m_araddr/m_arvalid/m_arready  out/out/in  ADDR_W/1/1  master read-address channel
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  master read-data channel

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP. Registers: state, grant (0/1), rr_ptr (0/1), aw_done, w_done.
- Reset (rst=0 at a clk edge): state=IDLE, grant=0, rr_ptr=0, aw_done=w_done=0.
- While in reset and in IDLE: every valid output (m_awvalid, m_wvalid, m_arvalid, sN_bvalid, sN_rvalid) = 0. Every ready output (sN_awready, sN_wready, sN_arready, m_bready, m_rready) = 0. Data outputs = 0.
- Request per port: rdreq_N = sN_arvalid; wrreq_N = sN_awvalid & sN_wvalid (a write needs both AW and W pending). reqN = rdreq_N | wrreq_N.
- IDLE arbitration:
  - Only one port requesting: grant that port.
  - Both requesting: grant rr_ptr.
  - Within the granted port, a read wins over a write.
  - Next state is RD_ADDR or WR_ADDR; no request keeps IDLE. Grant is registered, so a request seen at edge N drives m_arvalid/m_awvalid from cycle N+1.
- RD_ADDR: m_araddr = s[grant]_araddr; m_arvalid = 1; s[grant]_arready = m_arready. On m_arvalid & m_arready, go to RD_DATA.
- RD_DATA: s[grant]_rdata/rresp/rvalid = m_*; m_rready = s[grant]_rready. On m_rvalid & m_rready: state=IDLE, rr_ptr = ~grant.
- WR_ADDR:
  - AW and W are forwarded independently: m_awvalid = ~aw_done, m_wvalid = ~w_done.
  - s[grant]_awready = m_awready & ~aw_done; s[grant]_wready = m_wready & ~w_done.
  - Each handshake sets its done flag. Same-cycle handshake of both channels is allowed.
  - When both handshakes are complete (registered or current cycle), go to WR_RESP and clear the flags.
- WR_RESP: s[grant]_bresp/bvalid = m_*; m_bready = s[grant]_bready. On m_bvalid & m_bready: state=IDLE, rr_ptr = ~grant.
- The non-granted port always sees all readies = 0 and all response valids = 0. Its pending requests hold until it is granted (AXI valid-stability is the master's duty).
- SLVERR/DECERR responses pass through unaltered. The arbiter never generates responses.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- Reset asserted mid-transaction: the FSM returns to IDLE at that edge and any in-flight transaction is abandoned. The RAM and both masters share the same reset.
- No combinational path from sN_*valid to m_*valid. There is a combinational path from m_*ready to sN_*ready and from m_* responses to sN_* responses.

Optional Feature:
- AXIL_ARB_FIXED_PRIO_EN defined: rr_ptr is ignored, and on a conflict port 1 (dmem) always wins. Port 0 can starve; this mode is for latency-critical data-path testing.
- Not defined: round-robin as described above.

Test Plan:
- Single s0 read, araddr=0x0000_0100, RAM holds 0xDEAD_BEEF -> m_arvalid rises one cycle after s0_arvalid; s0_rdata=0xDEAD_BEEF, rresp=0; s1 readies stay 0.
- s1 write, addr=0x200, data=0x1234_5678, wstrb=0xF, AW valid 2 cycles before W -> no m_awvalid until both are pending; bresp=0; a following s1 read of 0x200 returns 0x1234_5678.
- Both ports issue a read every cycle for 8 transactions -> grant order 0,1,0,1,... with each port receiving exactly 4 responses.
- s0 holding rready=0 for 5 cycles during RD_DATA -> m_rready=0 and s1's pending read is not granted until s0 accepts rdata.
- Reset (rst=0) asserted in WR_ADDR after the AW handshake only -> all valids/readies are 0 next cycle and state is IDLE; after release, a new s0 read completes normally.
- With AXIL_ARB_FIXED_PRIO_EN, both ports requesting continuously for 4 transactions -> all 4 grants go to s1.
